// File: rtl/alu8_seq.sv
// alu8_seq: sequential ALU with single-cycle logic/arith ops and iterative unsigned MUL/DIV
module alu8_seq #(
  parameter int WIDTH = 8,
  parameter int ITER  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v
);
  localparam int M = WIDTH - 1;
  localparam int CW = $clog2(ITER + 1);
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_MUL = 4'h8;
  localparam logic [3:0] OP_DIV = 4'h9;
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opb_q, acc_q, acc_d, lo_q, lo_d;
  logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d;
  logic [3:0] op_q;
  logic z_q, c_q, n_q, v_q, z_d, c_d, n_d, v_d, done_q;
  logic accept, long_op, div_ge;
  logic [WIDTH:0] mul_sum, div_t, sum, dif;
  logic [WIDTH-1:0] div_r;
  assign accept = state_q == S_IDLE && start;
  assign long_op = (op == OP_MUL || op == OP_DIV) && b != '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      lo_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      op_q <= '0;
      done_q <= 1'b0;
      res_q <= '0;
      hi_q <= '0;
      {z_q, c_q, n_q, v_q} <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      lo_q <= lo_d;
      if (accept) begin
        opa_q <= a;
        opb_q <= b;
        op_q <= op;
      end
      done_q <= state_q == S_DONE;
      if (state_q == S_DONE) begin
        res_q <= res_d;
        hi_q <= hi_d;
        {z_q, c_q, n_q, v_q} <= {z_d, c_d, n_d, v_d};
      end
    end
  end
  always_comb begin
    state_d = state_q;
    if (accept) state_d = long_op ? S_ITER : S_DONE;
    else if (state_q == S_ITER && cnt_q == CW'(1)) state_d = S_DONE;
    else if (state_q == S_DONE) state_d = S_IDLE;
  end
  // acc holds the product high byte / running remainder; lo holds multiplier / dividend-then-quotient
  assign mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
  assign div_t = {acc_q, lo_q[M]};
  assign div_ge = div_t >= {1'b0, opb_q};
  assign div_r = div_t[M:0] - opb_q;
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    lo_d = lo_q;
    if (accept) begin
      cnt_d = CW'(ITER);
      acc_d = '0;
      lo_d = op == OP_MUL ? b : a;
    end else if (state_q == S_ITER) begin
      cnt_d = cnt_q - CW'(1);
      acc_d = op_q == OP_MUL ? mul_sum[WIDTH:1] : (div_ge ? div_r : div_t[M:0]);
      lo_d = op_q == OP_MUL ? {mul_sum[0], lo_q[M:1]} : {lo_q[M-1:0], div_ge};
    end
  end
  assign sum = {1'b0, opa_q} + {1'b0, opb_q};
  assign dif = {1'b0, opa_q} - {1'b0, opb_q};
  always_comb begin
    res_d = '0;
    hi_d = '0;
    c_d = 1'b0;
    v_d = 1'b0;
    case (op_q)
      OP_ADD: begin
        {c_d, res_d} = sum;
        v_d = opa_q[M] == opb_q[M] && sum[M] != opa_q[M];
      end
      OP_SUB: begin
        {c_d, res_d} = dif;
        v_d = opa_q[M] != opb_q[M] && dif[M] != opa_q[M];
      end
      OP_AND: res_d = opa_q & opb_q;
      OP_OR:  res_d = opa_q | opb_q;
      OP_XOR: res_d = opa_q ^ opb_q;
      OP_NOT: res_d = ~opa_q;
      OP_SHL: begin
        res_d = {opa_q[M-1:0], 1'b0};
        c_d = opa_q[M];
      end
      OP_SHR: begin
        res_d = {1'b0, opa_q[M:1]};
        c_d = opa_q[0];
      end
      OP_MUL: begin
        res_d = lo_q;
        hi_d = acc_q;
        c_d = |acc_q;
      end
      OP_DIV: begin
        res_d = opb_q == '0 ? '1 : lo_q;
        hi_d = opb_q == '0 ? opa_q : acc_q;
        v_d = opb_q == '0;
      end
      default: ;
    endcase
    z_d = op_q == OP_MUL ? ~|{hi_d, res_d} : ~|res_d;
    n_d = res_d[M];
  end
  assign busy = state_q == S_ITER;
  assign done = done_q;
  assign result = res_q;
  assign result_hi = hi_q;
  assign flag_z = z_q;
  assign flag_c = c_q;
  assign flag_n = n_q;
  assign flag_v = v_q;
endmodule

// File: tb/tb_alu8_seq.sv
// tb_alu8_seq: directed and randomized checks of alu8_seq against an arithmetic reference model
module tb_alu8_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [3:0] op = '0;
  logic busy, done, flag_z, flag_c, flag_n, flag_v;
  logic [7:0] result, result_hi;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct packed {logic [7:0] r; logic [7:0] h; logic z; logic c; logic n; logic v;} res_t;
  typedef struct packed {logic [7:0] a; logic [7:0] b; logic [3:0] op; res_t e;} vec_t;

  alu8_seq dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .start(start),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  function automatic res_t cur();
    return {result, result_hi, flag_z, flag_c, flag_n, flag_v};
  endfunction

  function automatic res_t model(input logic [7:0] x, input logic [7:0] y, input logic [3:0] o);
    res_t e = '0;
    int ix = int'(x);
    int iy = int'(y);
    int sx = int'($signed(x));
    int sy = int'($signed(y));
    int t;
    case (o)
      4'h0: begin t = ix + iy; e.r = 8'(t); e.c = t > 255; e.v = sx + sy > 127 || sx + sy < -128; end
      4'h1: begin e.r = 8'(ix - iy); e.c = ix < iy; e.v = sx - sy > 127 || sx - sy < -128; end
      4'h2: e.r = x & y;
      4'h3: e.r = x | y;
      4'h4: e.r = x ^ y;
      4'h5: e.r = ~x;
      4'h6: begin e.r = 8'(ix * 2); e.c = ix >= 128; end
      4'h7: begin e.r = 8'(ix / 2); e.c = ix % 2 == 1; end
      4'h8: begin t = ix * iy; e.r = 8'(t); e.h = 8'(t / 256); e.c = t > 255; end
      4'h9: begin
        if (iy == 0) begin e.r = 8'hFF; e.h = x; e.v = 1'b1; end
        else begin e.r = 8'(ix / iy); e.h = 8'(ix % iy); end
      end
      default: ;
    endcase
    e.z = o == 4'h8 ? ix * iy == 0 : e.r == 8'h00;
    e.n = e.r[7];
    return e;
  endfunction

  function automatic int exp_lat(input logic [3:0] o, input logic [7:0] y);
    return ((o == 4'h8 || o == 4'h9) && y != 0) ? 9 : 1;
  endfunction

  // Issues one op from a negedge; optionally scrambles inputs (and pulses start) while busy.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [3:0] o, input bit noise,
                        output int lat, output int bcnt, output bit held, output res_t obs, output bit spur);
    res_t prev = cur();
    a = x; b = y; op = o; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    bcnt = 0;
    held = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (done) begin lat = i; break; end
      if (busy) bcnt++;
      if (cur() !== prev) held = 1'b0;
      if (noise) begin
        a = 8'($urandom); b = 8'($urandom); op = 4'($urandom);
        start = busy ? 1'($urandom) : 1'b0;
      end
      @(negedge clk);
    end
    obs = cur();
    start = 1'b0;
    spur = 1'b0;
    repeat (2) begin
      @(negedge clk);
      spur |= busy | done;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (cur() !== res_t'(0)) begin n_fail++; $display("FAIL reset_outputs got %h want %h", cur(), res_t'(0)); end
    n_tests++;
    if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done got %b want 00", {busy, done}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    vec_t dir [19] = '{
      {8'hFF, 8'h01, 4'h0, 8'h00, 8'h00, 4'b1100},
      {8'h80, 8'h01, 4'h1, 8'h7F, 8'h00, 4'b0001},
      {8'h00, 8'h01, 4'h1, 8'hFF, 8'h00, 4'b0110},
      {8'hFF, 8'hFF, 4'h8, 8'h01, 8'hFE, 4'b0100},
      {8'hC8, 8'h07, 4'h9, 8'h1C, 8'h04, 4'b0000},
      {8'h35, 8'h00, 4'h9, 8'hFF, 8'h35, 4'b0011},
      {8'h10, 8'h10, 4'h8, 8'h00, 8'h01, 4'b0100},
      {8'h55, 8'hA7, 4'hC, 8'h00, 8'h00, 4'b1000},
      {8'h00, 8'hFF, 4'h2, 8'h00, 8'h00, 4'b1000},
      {8'h00, 8'hFF, 4'h3, 8'hFF, 8'h00, 4'b0010},
      {8'h00, 8'hFF, 4'h4, 8'hFF, 8'h00, 4'b0010},
      {8'hFF, 8'hFF, 4'h4, 8'h00, 8'h00, 4'b1000},
      {8'h0F, 8'h00, 4'h5, 8'hF0, 8'h00, 4'b0010},
      {8'h81, 8'h00, 4'h6, 8'h02, 8'h00, 4'b0100},
      {8'h81, 8'h00, 4'h7, 8'h40, 8'h00, 4'b0100},
      {8'h7F, 8'h01, 4'h0, 8'h80, 8'h00, 4'b0011},
      {8'h02, 8'h03, 4'h0, 8'h05, 8'h00, 4'b0000},
      {8'h05, 8'h09, 4'h9, 8'h00, 8'h05, 4'b1000},
      {8'h00, 8'h05, 4'h8, 8'h00, 8'h00, 4'b1000}
    };
    int lat, bcnt;
    bit held, spur;
    res_t obs;
    foreach (dir[k]) begin
      run_op(dir[k].a, dir[k].b, dir[k].op, 1'b1, lat, bcnt, held, obs, spur);
      n_tests++;
      if (obs !== dir[k].e) begin n_fail++; $display("FAIL dir%0d_out got %h want %h", k, obs, dir[k].e); end
      n_tests++;
      if (lat != exp_lat(dir[k].op, dir[k].b)) begin
        n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", k, lat, exp_lat(dir[k].op, dir[k].b));
      end
      n_tests++;
      if (bcnt != exp_lat(dir[k].op, dir[k].b) - 1) begin
        n_fail++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", k, bcnt, exp_lat(dir[k].op, dir[k].b) - 1);
      end
      n_tests++;
      if (!held || spur) begin n_fail++; $display("FAIL dir%0d_hold_spurious got held=%0b spur=%0b want 1/0", k, held, spur); end
    end
  endtask

  task automatic test_random();
    int lat, bcnt;
    bit held, spur;
    res_t obs, e;
    logic [7:0] x, y;
    logic [3:0] o;
    for (int k = 0; k < 150; k++) begin
      o = 4'($urandom_range(0, 15));
      x = 8'($urandom);
      y = 8'($urandom);
      if (o == 4'h8 && y == 0) y = 8'h01;
      if (o == 4'h9 && $urandom_range(0, 7) == 0) y = 8'h00;
      e = model(x, y, o);
      run_op(x, y, o, 1'b1, lat, bcnt, held, obs, spur);
      n_tests++;
      if (obs !== e || lat != exp_lat(o, y) || bcnt != exp_lat(o, y) - 1 || !held || spur) begin
        n_fail++;
        $display("FAIL rand%0d op=%h a=%h b=%h got out=%h lat=%0d busy=%0d held=%0b spur=%0b want out=%h lat=%0d",
                 k, o, x, y, obs, lat, bcnt, held, spur, e, exp_lat(o, y));
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat = -1;
    a = 8'h10; b = 8'h10; op = 4'h8; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin lat = i; break; end
      a = 8'($urandom); b = 8'($urandom);
      if (i == 2) begin a = 8'h01; b = 8'h02; op = 4'h0; end
      start = i == 2;
      @(negedge clk);
    end
    start = 1'b0;
    n_tests++;
    if (lat != 9) begin n_fail++; $display("FAIL ign_latency got %0d want 9", lat); end
    n_tests++;
    if (cur() !== res_t'({8'h00, 8'h01, 4'b0100})) begin
      n_fail++; $display("FAIL ign_out got %h want %h", cur(), res_t'({8'h00, 8'h01, 4'b0100}));
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL ign_dropped got %b want 00", {busy, done}); end
  endtask

  task automatic test_abort();
    int lat, bcnt, seen = 0;
    bit held, spur;
    res_t obs;
    a = 8'h23; b = 8'h45; op = 4'h8; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before got %b want 1", busy); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_tests++;
    if ({cur(), busy, done} !== 22'h0) begin
      n_fail++; $display("FAIL abort_cleared got out=%h busy=%b done=%b want all 0", cur(), busy, done);
    end
    repeat (12) begin
      @(negedge clk);
      seen += int'(done);
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses want 0", seen); end
    run_op(8'h02, 8'h03, 4'h0, 1'b0, lat, bcnt, held, obs, spur);
    n_tests++;
    if (obs !== res_t'({8'h05, 8'h00, 4'b0000}) || lat != 1) begin
      n_fail++; $display("FAIL abort_next_add got %h lat=%0d want %h lat=1", obs, lat, res_t'({8'h05, 8'h00, 4'b0000}));
    end
  endtask

  task automatic test_back_to_back();
    int cnt = 0;
    a = 8'h12; b = 8'h34; op = 4'h0; start = 1'b1;
    repeat (20) begin
      @(negedge clk);
      cnt += int'(done);
    end
    start = 1'b0;
    n_tests++;
    if (cnt != 10 || result !== 8'h46) begin
      n_fail++; $display("FAIL b2b_single got %0d dones result=%h want 10 dones result=46", cnt, result);
    end
    repeat (3) @(negedge clk);
    cnt = 0;
    a = 8'h0D; b = 8'h0B; op = 4'h8; start = 1'b1;
    repeat (40) begin
      @(negedge clk);
      cnt += int'(done);
    end
    start = 1'b0;
    n_tests++;
    if (cnt != 4 || {result_hi, result} !== 16'h008F) begin
      n_fail++; $display("FAIL b2b_mul got %0d dones product=%h want 4 dones product=008F", cnt, {result_hi, result});
    end
    repeat (12) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
